// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
// Store-kind codes mirror the core's ALU encoding so the snoop matches data memory.
package uart_pkg;

    localparam logic        ENABLE  = 1'b1;
    localparam logic [5:0]  ALU_ADD = 6'd0;
    localparam logic [5:0]  ALU_LB  = 6'd18;
    localparam logic [5:0]  ALU_LH  = 6'd19;
    localparam logic [5:0]  ALU_LW  = 6'd20;
    localparam logic [5:0]  ALU_SB  = 6'd23;
    localparam logic [5:0]  ALU_SH  = 6'd24;
    localparam logic [5:0]  ALU_SW  = 6'd25;

    localparam logic [31:0] DEFAULT_UART_ADDR = 32'hf6ff_f070;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Any store width counts; only the low byte is ever transmitted.
    function automatic logic is_store_code(input logic [5:0] alucode);
        return (alucode == ALU_SB) || (alucode == ALU_SH) || (alucode == ALU_SW);
    endfunction

endpackage

// File: rtl/uart_tx_mmio_sync_fifo.sv
// Small synchronous FIFO with extra-MSB pointers so full and empty are distinguishable.
// Head entry is read combinationally so the transmitter can load it in the pop cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr_reg;
    logic [PW-1:0]    rptr_reg;
    logic [PW-1:0]    wptr_next;
    logic [PW-1:0]    rptr_next;
    logic             do_push;
    logic             do_pop;

    assign empty = (wptr_reg == rptr_reg);
    assign full  = (wptr_reg[PW-1] != rptr_reg[PW-1]) &&
                   (wptr_reg[AW-1:0] == rptr_reg[AW-1:0]);
    assign level = wptr_reg - rptr_reg;
    assign dout  = mem[rptr_reg[AW-1:0]];

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wptr_next = wptr_reg;
        rptr_next = rptr_reg;
        if (do_push) begin
            wptr_next = wptr_reg + PW'(1);
        end
        if (do_pop) begin
            rptr_next = rptr_reg + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_reg <= '0;
            rptr_reg <= '0;
        end else begin
            wptr_reg <= wptr_next;
            rptr_reg <= rptr_next;
        end
    end

    // Storage carries no reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr_reg[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Store-path UART transmitter: snoops stores to the TX register, queues the low byte,
// and sends 8N1 frames back-to-back; stalls the core while the queue is full.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 434,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] UART_ADDR    = DEFAULT_UART_ADDR
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [5:0]                    alucode,
    input  logic                          is_store,
    input  logic [31:0]                   addr_w,
    input  logic [31:0]                   data_w,
    output logic                          stall,
    output logic                          uart_tx,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level
);

    localparam int          CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    logic        hit;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    logic [7:0]  head;

    uart_state_t   state_reg;
    uart_state_t   state_next;
    logic [CW-1:0] baud_reg;
    logic [CW-1:0] baud_next;
    logic [2:0]    bit_idx_reg;
    logic [2:0]    bit_idx_next;
    logic [7:0]    shift_reg;
    logic [7:0]    shift_next;
    logic          uart_tx_reg;
    logic          uart_tx_next;
    logic          baud_last;

    // Stall uses only inputs and registered full, so it never loops back into the decode.
    assign hit   = (is_store == ENABLE) && (addr_w == UART_ADDR) && is_store_code(alucode);
    assign stall = hit && full;
    assign push  = hit && !full;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (data_w[7:0]),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (tx_level)
    );

    assign baud_last = (baud_reg == BAUD_LAST);

    always_comb begin
        state_next   = state_reg;
        baud_next    = baud_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        pop          = 1'b0;

        case (state_reg)
            IDLE: begin
                if (!empty) begin
                    pop          = 1'b1;
                    shift_next   = head;
                    baud_next    = '0;
                    bit_idx_next = '0;
                    state_next   = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_next  = '0;
                    state_next = DATA;
                end else begin
                    baud_next = baud_reg + CW'(1);
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_next    = '0;
                    shift_next   = {1'b0, shift_reg[7:1]};
                    bit_idx_next = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = STOP;
                    end
                end else begin
                    baud_next = baud_reg + CW'(1);
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_next = '0;
                    // Chain straight into the next start bit when more bytes wait.
                    if (!empty) begin
                        pop          = 1'b1;
                        shift_next   = head;
                        bit_idx_next = '0;
                        state_next   = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud_reg + CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Line level is derived from the upcoming state so the register changes with the FSM.
    always_comb begin
        case (state_next)
            START:   uart_tx_next = 1'b0;
            DATA:    uart_tx_next = shift_next[0];
            default: uart_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            baud_reg    <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            uart_tx_reg <= 1'b1;
        end else begin
            state_reg   <= state_next;
            baud_reg    <= baud_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            uart_tx_reg <= uart_tx_next;
        end
    end

    assign uart_tx = uart_tx_reg;

endmodule
